// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges per-unit execute results onto NUM_CDB registered
// broadcast ports, with a per-source FIFO for losers and branch-first priority.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [6:0]  prd;
    logic [31:0] rd_v;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC   = 5,
  parameter int NUM_CDB   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int BR_IDX    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               global_branch_signal,
  input  cdb_t               cdb_in  [NUM_SRC],
  output cdb_t               cdb_out [NUM_CDB],
  output logic [NUM_SRC-1:0] stall,
  output logic               overflow
);

  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int RW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NW  = $clog2(NUM_CDB + 1);
  localparam int PIW = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  cdb_t          mem_q    [NUM_SRC][BUF_DEPTH];
  logic [PW-1:0] rd_ptr_q [NUM_SRC];
  logic [PW-1:0] wr_ptr_q [NUM_SRC];
  logic [CW-1:0] count_q  [NUM_SRC];
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t          out_q    [NUM_CDB];
  cdb_t          out_d    [NUM_CDB];
  logic          overflow_q;

  cdb_t               cand [NUM_SRC];
  logic [NUM_SRC-1:0] cand_vld, fifo_empty, gnt, pop, push, drop;
  logic [RW:0]        sum;
  logic [RW-1:0]      s;
  logic [NW-1:0]      n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO head takes precedence over the live input so per-source order is kept.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fifo_empty[i] = (count_q[i] == '0);
      cand_vld[i]   = !fifo_empty[i] || cdb_in[i].valid;
      cand[i]       = fifo_empty[i] ? cdb_in[i] : mem_q[i][rd_ptr_q[i]];
    end
  end

  always_comb begin
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    n        = '0;
    sum      = '0;
    s        = '0;
    for (int p = 0; p < NUM_CDB; p++) out_d[p] = '0;

    if (cand_vld[BR_IDX]) begin
      gnt[BR_IDX] = 1'b1;
      out_d[0]    = cand[BR_IDX];
      n           = NW'(1);
    end

    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (sum >= (RW+1)'(NUM_SRC)) sum = sum - (RW+1)'(NUM_SRC);
      s = sum[RW-1:0];
      if (s != RW'(BR_IDX) && cand_vld[s] && n < NW'(NUM_CDB)) begin
        gnt[s]            = 1'b1;
        out_d[n[PIW-1:0]] = cand[s];
        n                 = n + 1'b1;
        rr_ptr_d          = (s == RW'(NUM_SRC - 1)) ? '0 : s + 1'b1;
      end
    end
  end

  // An input is pushed unless it went straight out; a full FIFO without a pop drops it.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = !fifo_empty[i] && gnt[i];
      drop[i] = cdb_in[i].valid && !(fifo_empty[i] && gnt[i]) &&
                (count_q[i] == CW'(BUF_DEPTH)) && !pop[i];
      push[i] = cdb_in[i].valid && !(fifo_empty[i] && gnt[i]) && !drop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || global_branch_signal) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      for (int p = 0; p < NUM_CDB; p++) out_q[p] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      for (int p = 0; p < NUM_CDB; p++) out_q[p] <= out_d[p];
    end
  end

  // Flush leaves the round-robin pointer and the sticky flag alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (!global_branch_signal) begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_q | (|drop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rst && !global_branch_signal && push[i]) mem_q[i][wr_ptr_q[i]] <= cdb_in[i];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) cdb_out[p] = out_q[p];
    for (int i = 0; i < NUM_SRC; i++) stall[i] = (count_q[i] >= CW'(BUF_DEPTH - 1));
  end

  assign overflow = overflow_q;

endmodule
